// File: rtl/cnn_sram_pkg.sv
// cnn_sram_pkg: shared SRAM enable polarity and count-width helper
package cnn_sram_pkg;
  localparam logic CEN_ON  = 1'b0;
  localparam logic CEN_OFF = 1'b1;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 3);
  endfunction
endpackage

// File: rtl/sram_fifo_mem.sv
// sram_fifo_mem: 1-write/1-read SRAM model with registered read data and active-low enables
module sram_fifo_mem
  import cnn_sram_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clka,
  input  logic [AW-1:0]    aa,
  input  logic             cena,
  output logic [WIDTH-1:0] qa,
  input  logic             clkb,
  input  logic [AW-1:0]    ab,
  input  logic             cenb,
  input  logic [WIDTH-1:0] db
);
  logic [WIDTH-1:0] mem [DEPTH];
  // read port: qa only changes on an enabled read, one cycle after the address
  always_ff @(posedge clka)
    if (cena == CEN_ON) qa <= mem[aa];
  // write port
  always_ff @(posedge clkb)
    if (cenb == CEN_ON) mem[ab] <= db;
endmodule

// File: rtl/sram_fwft_fifo.sv
// sram_fwft_fifo: SRAM-backed first-word-fall-through FIFO, capacity DEPTH+2; define SRAM_FIFO_BYPASS_EN for write-to-output bypass
module sram_fwft_fifo
  import cnn_sram_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 1024,
  parameter int AFULL_TH = DEPTH - 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [WIDTH-1:0]        wr_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [WIDTH-1:0]        rd_data,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    afull
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;
  localparam int CW = cnt_w(DEPTH);
  localparam logic [SW-1:0] FULL = SW'(DEPTH);
  localparam logic [CW-1:0] AF   = CW'(AFULL_TH);

  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [SW-1:0]    scnt_q, scnt_d;
  logic             infl_q, infl_d, out_v_q, out_v_d, skid_v_q, skid_v_d;
  logic             wr_ready_q, wr_ready_d;
  logic [WIDTH-1:0] out_q, out_d, skid_q, skid_d, qa, land_data;
  logic             push, pop, keep_v, keep_skid_v, sram_wr, rd_issue, cena, cenb;
`ifdef SRAM_FIFO_BYPASS_EN
  logic             bypass, byp_sel_q, byp_sel_d;
  logic [WIDTH-1:0] byp_q, byp_d;
`endif

  sram_fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clka(clk),
    .aa  (rptr_q),
    .cena(cena),
    .qa  (qa),
    .clkb(clk),
    .ab  (wptr_q),
    .cenb(cenb),
    .db  (wr_data)
  );

  // next state: output stage after this cycle's pop, read issue, landing, occupancy and pointers
  always_comb begin
    push        = wr_valid & wr_ready_q;
    pop         = out_v_q & rd_ready;
    keep_v      = pop ? skid_v_q : out_v_q;
    keep_skid_v = skid_v_q & ~pop;
    // issue only if the stage words kept past this pop plus the word in flight leave a slot
    rd_issue    = (scnt_q != '0) & ~keep_skid_v & ~(keep_v & infl_q);
`ifdef SRAM_FIFO_BYPASS_EN
    // an empty SRAM with nothing in flight lets the write ride the in-flight slot directly
    bypass      = push & (scnt_q == '0) & ~infl_q & ~keep_skid_v;
    byp_sel_d   = bypass;
    byp_d       = bypass ? wr_data : byp_q;
    land_data   = byp_sel_q ? byp_q : qa;
    sram_wr     = push & ~bypass;
    infl_d      = rd_issue | bypass;
`else
    land_data   = qa;
    sram_wr     = push;
    infl_d      = rd_issue;
`endif
    out_v_d     = keep_v | infl_q;
    out_d       = keep_v ? (pop ? skid_q : out_q) : (infl_q ? land_data : out_q);
    skid_v_d    = keep_skid_v | (keep_v & infl_q);
    skid_d      = (keep_v & infl_q) ? land_data : skid_q;
    scnt_d      = scnt_q + SW'(sram_wr) - SW'(rd_issue);
    wptr_d      = sram_wr ? wptr_q + AW'(1) : wptr_q;
    rptr_d      = rd_issue ? rptr_q + AW'(1) : rptr_q;
    wr_ready_d  = scnt_d < FULL;
    cena        = rd_issue ? CEN_ON : CEN_OFF;
    cenb        = sram_wr ? CEN_ON : CEN_OFF;
  end

  // state registers, cleared asynchronously so a reset discards all held words
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      scnt_q     <= '0;
      infl_q     <= 1'b0;
      out_v_q    <= 1'b0;
      skid_v_q   <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      scnt_q     <= scnt_d;
      infl_q     <= infl_d;
      out_v_q    <= out_v_d;
      skid_v_q   <= skid_v_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      wr_ready_q <= wr_ready_d;
    end

`ifdef SRAM_FIFO_BYPASS_EN
  // bypass word holding register, stands in for the SRAM read data for one cycle
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      byp_sel_q <= 1'b0;
      byp_q     <= '0;
    end else begin
      byp_sel_q <= byp_sel_d;
      byp_q     <= byp_d;
    end
`endif

  assign wr_ready = wr_ready_q;
  assign rd_valid = out_v_q;
  assign rd_data  = out_q;
  assign count    = CW'(scnt_q) + CW'(infl_q) + CW'(out_v_q) + CW'(skid_v_q);
  assign afull    = count >= AF;
endmodule

// File: tb/tb_sram_fwft_fifo.sv
// tb_sram_fwft_fifo: directed and random checks of sram_fwft_fifo with a read-order scoreboard
module tb_sram_fwft_fifo;
  localparam int WIDTH = 16, DEPTH = 8, AFULL_TH = 6;
`ifdef SRAM_FIFO_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  logic             clk = 1'b0, rstn = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
  logic             wr_ready, rd_valid, afull;
  logic [WIDTH-1:0] wr_data = '0, rd_data;
  logic [3:0]       count;
  int               n_cmp = 0, n_err = 0, max_cnt = 0;
  logic [WIDTH-1:0] exp_q[$];

  sram_fwft_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .clk(clk), .rstn(rstn), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .count(count), .afull(afull)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: accepted writes queue up, every accepted read must match the queue head
  always @(negedge clk)
    if (rstn) begin
      if (wr_valid && wr_ready) exp_q.push_back(wr_data);
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rd_extra: got %0h expected no word", rd_data);
        end else chk("rd_order", rd_data, exp_q.pop_front());
      end
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic a;
    int acc, wrote, cyc;
    acc = 0;
    wrote = 0;
    #12;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_count", count, 0);
    chk("rst_afull", afull, 0);
    #8 rstn = 1'b1;
    tick();
    chk("rel_wr_ready", wr_ready, 1);
    chk("rel_count", count, 0);
    // fill with the reader stalled
    for (int v = 1; v <= 11; v++) begin
      wr_valid = 1'b1;
      wr_data  = 16'(v);
      a = wr_ready;
      tick();
      if (a) acc++;
      chk("fill_count", count, acc);
      chk("fill_afull", afull, acc >= 6);
    end
    tick();
    chk("fill_accepted", acc, 10);
    chk("fill_wr_ready", wr_ready, 0);
    chk("fill_count_hold", count, 10);
    wr_valid = 1'b0;
    // drain back to back
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("drain_valid", rd_valid, 1);
      chk("drain_data", rd_data, i + 1);
      tick();
    end
    chk("drain_end_valid", rd_valid, 0);
    chk("drain_end_count", count, 0);
    rd_ready = 1'b0;
    // write-to-valid latency
    wr_valid = 1'b1;
    wr_data  = 16'hBEEF;
    tick();
    wr_valid = 1'b0;
    chk("lat_count", count, 1);
    chk("lat_early", rd_valid, 0);
    for (int k = 1; k <= LAT; k++) begin
      tick();
      chk("lat_valid", rd_valid, k == LAT);
    end
    chk("lat_data", rd_data, 16'hBEEF);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("lat_drained", count, 0);
    // random traffic
    cyc = 0;
    while (wrote < 1000 && cyc < 20000) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_data  = 16'($urandom);
      rd_ready = 1'($urandom_range(0, 1));
      a = wr_valid && wr_ready;
      tick();
      if (a) wrote++;
      cyc++;
    end
    chk("rnd_written", wrote, 1000);
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    cyc = 0;
    while (count != 0 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("rnd_drain_count", count, 0);
    chk("rnd_sb_empty", exp_q.size(), 0);
    chk("rnd_max_count_over10", max_cnt > 10, 0);
    // reset in the middle of operation
    rd_ready = 1'b0;
    for (int v = 0; v < 5; v++) begin
      wr_valid = 1'b1;
      wr_data  = 16'(16'h50 + v);
      tick();
    end
    wr_valid = 1'b0;
    chk("mid_count", count, 5);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", rd_valid, 0);
    chk("mid_rst_wr_ready", wr_ready, 0);
    exp_q.delete();
    #3 rstn = 1'b1;
    tick();
    chk("mid_rel_wr_ready", wr_ready, 1);
    wr_valid = 1'b1;
    wr_data  = 16'h1234;
    tick();
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    cyc = 0;
    while (!rd_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("mid_first_valid", rd_valid, 1);
    chk("mid_first_data", rd_data, 16'h1234);
    tick();
    rd_ready = 1'b0;
    chk("mid_end_count", count, 0);
    chk("mid_sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sram_fwft_fifo.md
SRAM_FWFT_FIFO -- requirements
Module: sram_fwft_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024: number of SRAM entries, power of two, at least 4.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-4: count threshold for afull.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have ports wr_valid (input, 1 bit), wr_ready (output, 1 bit) and wr_data (input, WIDTH bits): the write handshake.
REQ-007 SHALL have ports rd_valid (output, 1 bit), rd_ready (input, 1 bit) and rd_data (output, WIDTH bits): the first-word-fall-through read handshake.
REQ-008 SHALL have port count, output, $clog2(DEPTH+3) bits: total words held.
REQ-009 SHALL have port afull, output, 1 bit: high when count >= AFULL_TH.

Function
REQ-010 SHALL accept a write on a clock edge where wr_valid && wr_ready, and deliver a read on a clock edge where rd_valid && rd_ready.
REQ-011 SHALL store words in a 1-write/1-read SRAM with 1-cycle registered read latency, followed by a 2-entry output stage (output register plus skid register).
REQ-012 SHALL have total capacity DEPTH+2, where count = SRAM occupancy + in-flight read + output-stage occupancy.
REQ-013 SHALL drive wr_ready = (SRAM occupancy < DEPTH), registered, with no combinational path from rd_ready.
REQ-014 SHALL issue an SRAM read (CEN low) when the SRAM is non-empty and (output-stage occupancy + in-flight reads) < 2.
REQ-015 SHALL land returning SRAM data in the output register if it is free, else in the skid register; the skid register drains into the output register first.
REQ-016 SHALL hold rd_data at the head word while rd_valid is high, and keep it stable until the word is accepted.
REQ-017 SHALL deliver back-to-back reads, one word per cycle with no bubbles, while rd_ready is held high and the SRAM is non-empty.
REQ-018 SHALL keep read and write pointers at $clog2(DEPTH) bits, wrap them modulo DEPTH, and track full/empty with a separate occupancy counter.
REQ-019 SHALL update count correctly on a simultaneous write and read in the same cycle: count unchanged.
REQ-020 SHALL ignore wr_valid while full and SHALL never drop or duplicate a word; rd_valid low while empty.
REQ-021 SHALL preserve strict FIFO order under all handshake patterns.
REQ-022 SHALL, when the macro of REQ-027 is not defined, assert rd_valid for a word written into an empty block 2 cycles after the write edge.

Reset
REQ-023 SHALL, while rstn is low, asynchronously clear pointers, occupancy, in-flight flag and output stage.
REQ-024 SHALL drive these output values while rstn is low: wr_ready=0, rd_valid=0, rd_data=0, count=0, afull=0.
REQ-025 SHALL drive wr_ready=1 on the first edge after reset release.
REQ-026 SHALL discard contents on a reset mid-operation; SRAM array contents are not reset.

Configuration
REQ-027 SHALL compile the write-to-output bypass in when SRAM_FIFO_BYPASS_EN is defined: a write into a block with an empty SRAM, no read in flight and a free output-stage slot goes directly to the output stage, and rd_valid asserts 1 cycle after the write edge.
REQ-028 SHALL, without SRAM_FIFO_BYPASS_EN, route every word through the SRAM, giving the 2-cycle latency of REQ-022; order and capacity are identical in both builds.

Structure
REQ-029 SHALL place the SRAM CEN active-low constant and the count-width helper function in shared package cnn_sram_pkg.
REQ-030 SHALL use exactly one sub-module, sram_fifo_mem: a parametrised 1w1r SRAM with ports clka/aa/cena/qa and clkb/ab/cenb/db, registered qa.

Verification (WIDTH=16, DEPTH=8, AFULL_TH=6)
REQ-031 SHALL check reset: rstn low -> all outputs 0; one edge after release -> wr_ready=1, count=0.
REQ-032 SHALL check fill: rd_ready=0, write 0x0001..0x000B -> 10 words accepted, wr_ready=0 after the 10th, count=10, afull first high when count=6.
REQ-033 SHALL check drain: after fill, rd_ready=1 -> 0x0001..0x000A on 10 consecutive cycles, then rd_valid=0, count=0.
REQ-034 SHALL check latency: single write 0xBEEF into an empty block -> rd_valid high 2 cycles later (1 cycle with SRAM_FIFO_BYPASS_EN).
REQ-035 SHALL check random traffic: 1000 words, random 50% wr_valid and rd_ready -> scoreboard order exact, count <= 10, no loss or duplication.
REQ-036 SHALL check mid-operation reset: count=5, pulse rstn low -> count=0 and rd_valid=0 immediately, and the next write 0x1234 is read first.
